bridge_src_ctrl_mo: RTL and testbench
=====================================

# bridge_src_ctrl_mo

Source-domain controller for the AHB-to-AHB bridge. Supports up to MAX_OUTSTANDING pipelined reads, tagged with a wrapping ID. Converts slave-side transfers into tagged request packets for the request CDC FIFO and matches tagged response packets from the response CDC FIFO. Runs a drain-then-sleep handshake with the sink domain and holds the CDC FIFOs in reset while asleep.

## Interface
- ADDR_WIDTH, 32, transfer address width
- DATA_WIDTH, 32, data width
- MAX_OUTSTANDING, 4, maximum reads in flight; power of two, 2..16
- ID_WIDTH, $clog2(MAX_OUTSTANDING), tag width (derived, do not override)
- TIMEOUT_CYCLES, 256, read timeout (only with macro)
- i_clk_src  in  1  source clock
- i_rstn_src  in  1  asynchronous, active-low reset
- i_src_sleep_req  in  1  local sleep request
- i_sink_sleep_status  in  1  sink domain asleep or entering sleep
- i_valid  in  1  slave transfer request
- i_rd0_wr1  in  1  0 = read, 1 = write
- i_addr  in  ADDR_WIDTH  address
- i_wr_data  in  DATA_WIDTH  write data
- o_ready  out  1  transfer accepted when i_valid && o_ready
- o_rd_data  out  DATA_WIDTH  read data
- o_rd_valid  out  1  read response strobe, one cycle
- o_rd_err  out  1  response error, qualified by o_rd_valid
- i_req_fifo_full  in  1  request FIFO full
- i_req_fifo_empty  in  1  request FIFO empty
- o_req_fifo_wr_en  out  1  push request
- o_req_packet  out  ID_WIDTH+ADDR_WIDTH+DATA_WIDTH+1  {tag, rd0_wr1, addr, wr_data}
- i_rsp_fifo_empty  in  1  response FIFO empty
- i_rsp_packet  in  ID_WIDTH+DATA_WIDTH+1  {tag, err, data}; first-word-fall-through
- o_rsp_fifo_rd_en  out  1  pop response
- o_outstanding  out  ID_WIDTH+1  reads in flight
- o_src_sleep_ack  out  1  sleep acknowledged
- o_source_sleep_status  out  1  source asleep by local request
- o_fifo_rstn  out  1  active-low reset to both CDC FIFOs

## Operation
- States:
  - ACTIVE: accept transfers.
  - DRAIN: no new transfers; responses are still popped.
  - SLEEP: FIFOs held in reset.
  - WAKE: one cycle; tags cleared.
- ACTIVE→DRAIN: i_src_sleep_req || i_sink_sleep_status.
- DRAIN→SLEEP: o_outstanding==0 && i_req_fifo_empty && i_rsp_fifo_empty.
- SLEEP→WAKE: !i_src_sleep_req && !i_sink_sleep_status.
- WAKE→ACTIVE: unconditional.
- o_ready = ACTIVE && !i_req_fifo_full && o_outstanding != MAX_OUTSTANDING. The condition is the same for writes, which keeps ready independent of i_rd0_wr1.
- Accept drives o_req_fifo_wr_en=1 combinationally in the same cycle.
- Packet tag field:
  - reads: issue_tag;
  - writes: 0.
- issue_tag increments (mod MAX_OUTSTANDING) per accepted read.
- Writes are posted and generate no response.
- o_rsp_fifo_rd_en = !i_rsp_fifo_empty && (ACTIVE || DRAIN) && o_outstanding != 0.
- On a pop:
  - o_outstanding decrements.
  - exp_tag increments.
  - Registered outputs next cycle: o_rd_valid=1, o_rd_data = packet data, o_rd_err = packet err || (packet tag != exp_tag).
- Simultaneous read accept and pop: o_outstanding unchanged.
- o_outstanding saturates by construction. A pop with o_outstanding==0 never occurs; an assertion flags it.
- SLEEP outputs:
  - o_fifo_rstn = 0;
  - o_src_sleep_ack = i_src_sleep_req;
  - o_source_sleep_status = i_src_sleep_req.
- In all other states these three outputs are 1, 0 and 0.
- WAKE: issue_tag = exp_tag = 0; o_ready = 0.

## Timing
- Reset values:
  - state ACTIVE;
  - o_rd_valid, o_rd_err, o_rd_data = 0;
  - o_outstanding, issue_tag, exp_tag = 0;
  - o_fifo_rstn = 1 (registered);
  - o_src_sleep_ack, o_source_sleep_status = 0.
- o_ready, o_req_fifo_wr_en, o_req_packet and o_rsp_fifo_rd_en are combinational from state and registered counts.
- Read response latency: o_rd_valid asserts one cycle after o_rsp_fifo_rd_en.
- o_src_sleep_ack and o_fifo_rstn are registered. Both change one cycle after SLEEP entry and one cycle after SLEEP exit.
- Sleep request arriving the same cycle as i_valid: the transfer is still accepted, because the state is still ACTIVE. DRAIN starts next cycle.
- Sleep request dropped while in DRAIN: DRAIN completes, SLEEP is entered, and WAKE follows immediately.
- Reset mid-transfer: all in-flight reads are lost. The sink side is reset through the same FIFO reset path.

## Configuration
- SRC_CTRL_RD_TIMEOUT_EN defined:
  - A counter runs while o_outstanding != 0 and no pop occurs. It clears on each pop.
  - When the counter reaches TIMEOUT_CYCLES-1:
    - emit o_rd_valid=1, o_rd_err=1, o_rd_data=0;
    - decrement o_outstanding;
    - increment exp_tag.
  - A late response whose tag != exp_tag is popped and discarded, with no o_rd_valid.
- Undefined:
  - no counter;
  - tag mismatch is reported as o_rd_err=1 with the data passed through;
  - TIMEOUT_CYCLES unused.

## Structure
- Package bridge_pkg holds:
  - the state enum (ACTIVE, DRAIN, SLEEP, WAKE);
  - packet field offset/width functions of ADDR_WIDTH, DATA_WIDTH and ID_WIDTH, shared with the sink controller.
- One sub-module, bridge_rsp_tracker, owns:
  - issue_tag, exp_tag and o_outstanding;
  - tag check;
  - timeout logic.
- The FSM and the request path stay in the top module.

## Test plan
- Write 0x1000←0xDEADBEEF with FIFO not full → o_req_fifo_wr_en=1 in the same cycle, packet {0,1,0x1000,0xDEADBEEF}, o_outstanding stays 0.
- 4 back-to-back reads (MAX_OUTSTANDING=4) → tags 0,1,2,3; o_ready=0 while o_outstanding=4. First response pop → o_ready=1 next cycle; o_rd_valid 1 cycle after pop.
- Response packet tag 2 while exp_tag=1 → o_rd_valid=1, o_rd_err=1 (macro off). With macro on, same packet after a timeout on tag 1 → discarded, no o_rd_valid.
- Assert i_src_sleep_req with 2 reads in flight → DRAIN, o_ready=0, both responses delivered, then SLEEP. o_src_sleep_ack=1 and o_fifo_rstn=0 one cycle later.
- In SLEEP, deassert i_src_sleep_req while i_sink_sleep_status=1 → stays in SLEEP. Deassert sink → WAKE, then ACTIVE; next read carries tag 0.
- Macro on, TIMEOUT_CYCLES=8, one read with no response → o_rd_valid=1, o_rd_err=1, o_rd_data=0 at cycle 8 after issue; o_outstanding=0.

Source files
------------

// File: rtl/bridge_pkg.sv
// Shared definitions for the AHB-to-AHB bridge source and sink controllers.
// Holds the controller state encoding and the request/response packet layout.
// Layout helpers are plain constant functions so both domains slice packets identically.
package bridge_pkg;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    DRAIN  = 2'd1,
    SLEEP  = 2'd2,
    WAKE   = 2'd3
  } state_t;

  // Request packet: {tag, rd0_wr1, addr, wr_data}
  function automatic int req_pkt_w(input int aw, input int dw, input int iw);
    return iw + aw + dw + 1;
  endfunction

  function automatic int req_addr_lsb(input int dw);
    return dw;
  endfunction

  function automatic int req_rw_bit(input int aw, input int dw);
    return aw + dw;
  endfunction

  function automatic int req_tag_lsb(input int aw, input int dw);
    return aw + dw + 1;
  endfunction

  // Response packet: {tag, err, data}
  function automatic int rsp_pkt_w(input int dw, input int iw);
    return iw + dw + 1;
  endfunction

  function automatic int rsp_err_bit(input int dw);
    return dw;
  endfunction

  function automatic int rsp_tag_lsb(input int dw);
    return dw + 1;
  endfunction

endpackage

// File: rtl/bridge_rsp_tracker.sv
// Read tag bookkeeping: issue/expected tags, reads-in-flight count, response check.
// Latency: response strobe/data/err registered one cycle after a pop (or a timeout).
// Backpressure: none; the parent gates accepts on outstanding and pops on FIFO state.
// Optional SRC_CTRL_RD_TIMEOUT_EN: retires a stalled read with an error after
// TIMEOUT_CYCLES and silently discards late responses whose tag no longer matches.
module bridge_rsp_tracker
  import bridge_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ID_WIDTH       = 2,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                         i_clk_src,
  input  logic                         i_rstn_src,
  input  logic                         rd_accept,
  input  logic                         pop,
  input  logic                         clear_tags,
  input  logic [ID_WIDTH+DATA_WIDTH:0] rsp_packet,
  output logic [ID_WIDTH-1:0]          issue_tag,
  output logic [ID_WIDTH:0]            outstanding,
  output logic                         rd_valid,
  output logic                         rd_err,
  output logic [DATA_WIDTH-1:0]        rd_data
);

  localparam int                RSP_TAG_LSB = rsp_tag_lsb(DATA_WIDTH);
  localparam int                RSP_ERR_BIT = rsp_err_bit(DATA_WIDTH);
  localparam logic [ID_WIDTH:0] OUT_ONE     = {{ID_WIDTH{1'b0}}, 1'b1};

  logic [ID_WIDTH-1:0]   exp_tag;
  logic [ID_WIDTH-1:0]   rsp_tag;
  logic                  rsp_err;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  tag_match;
  logic                  counted_pop;
  logic                  timeout_hit;
  logic                  dec;

  assign rsp_tag   = rsp_packet[RSP_TAG_LSB +: ID_WIDTH];
  assign rsp_err   = rsp_packet[RSP_ERR_BIT];
  assign rsp_data  = rsp_packet[DATA_WIDTH-1:0];
  assign tag_match = (rsp_tag == exp_tag);

`ifdef SRC_CTRL_RD_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] to_cnt;

  // A mismatching tag belongs to a read already retired by timeout: drop it.
  assign counted_pop = pop && tag_match && (outstanding != '0);
  assign timeout_hit = (outstanding != '0) && !pop
                       && (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Cycles since the last pop while reads are in flight.
  always_ff @(posedge i_clk_src or negedge i_rstn_src) begin
    if (!i_rstn_src) begin
      to_cnt <= '0;
    end else if (pop || timeout_hit || (outstanding == '0)) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + CNT_W'(1);
    end
  end
`else
  assign counted_pop = pop;
  assign timeout_hit = 1'b0;
`endif

  assign dec = counted_pop || timeout_hit;

  // Tag counters and reads-in-flight count; accept+retire in one cycle cancel.
  always_ff @(posedge i_clk_src or negedge i_rstn_src) begin
    if (!i_rstn_src) begin
      issue_tag   <= '0;
      exp_tag     <= '0;
      outstanding <= '0;
    end else begin
      if (clear_tags) begin
        issue_tag <= '0;
        exp_tag   <= '0;
      end else begin
        if (rd_accept) issue_tag <= issue_tag + ID_WIDTH'(1);
        if (dec)       exp_tag   <= exp_tag + ID_WIDTH'(1);
      end
      if (rd_accept && !dec) begin
        outstanding <= outstanding + OUT_ONE;
      end else if (!rd_accept && dec) begin
        outstanding <= outstanding - OUT_ONE;
      end
    end
  end

  // Registered read response; a tag mismatch is reported as an error.
  always_ff @(posedge i_clk_src or negedge i_rstn_src) begin
    if (!i_rstn_src) begin
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= dec;
      if (counted_pop) begin
        rd_data <= rsp_data;
        rd_err  <= rsp_err || !tag_match;
      end else if (timeout_hit) begin
        rd_data <= '0;
        rd_err  <= 1'b1;
      end
    end
  end

`ifndef SRC_CTRL_RD_TIMEOUT_EN
  a_no_pop_when_idle: assert property (@(posedge i_clk_src) disable iff (!i_rstn_src)
    !(pop && (outstanding == '0)));
`endif

endmodule

// File: rtl/bridge_src_ctrl_mo.sv
// Source-domain bridge controller: tagged requests out, tag-checked responses in, sleep handshake.
// Latency: request push is combinational with accept; read data one cycle after response pop.
// Backpressure: o_ready drops on request FIFO full, MAX_OUTSTANDING reads in flight, or non-ACTIVE.
// Optional SRC_CTRL_RD_TIMEOUT_EN enables the read timeout and late-response discard.
module bridge_src_ctrl_mo
  import bridge_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int ID_WIDTH        = $clog2(MAX_OUTSTANDING),
  parameter int TIMEOUT_CYCLES  = 256
) (
  input  logic                                    i_clk_src,
  input  logic                                    i_rstn_src,
  input  logic                                    i_src_sleep_req,
  input  logic                                    i_sink_sleep_status,
  input  logic                                    i_valid,
  input  logic                                    i_rd0_wr1,
  input  logic [ADDR_WIDTH-1:0]                   i_addr,
  input  logic [DATA_WIDTH-1:0]                   i_wr_data,
  output logic                                    o_ready,
  output logic [DATA_WIDTH-1:0]                   o_rd_data,
  output logic                                    o_rd_valid,
  output logic                                    o_rd_err,
  input  logic                                    i_req_fifo_full,
  input  logic                                    i_req_fifo_empty,
  output logic                                    o_req_fifo_wr_en,
  output logic [ID_WIDTH+ADDR_WIDTH+DATA_WIDTH:0] o_req_packet,
  input  logic                                    i_rsp_fifo_empty,
  input  logic [ID_WIDTH+DATA_WIDTH:0]            i_rsp_packet,
  output logic                                    o_rsp_fifo_rd_en,
  output logic [ID_WIDTH:0]                       o_outstanding,
  output logic                                    o_src_sleep_ack,
  output logic                                    o_source_sleep_status,
  output logic                                    o_fifo_rstn
);

  localparam int                REQ_TAG_LSB  = req_tag_lsb(ADDR_WIDTH, DATA_WIDTH);
  localparam int                REQ_RW_BIT   = req_rw_bit(ADDR_WIDTH, DATA_WIDTH);
  localparam int                REQ_ADDR_LSB = req_addr_lsb(DATA_WIDTH);
  localparam logic [ID_WIDTH:0] MAX_OUT      = (ID_WIDTH+1)'(MAX_OUTSTANDING);

  state_t              state;
  state_t              state_nxt;
  logic                accept;
  logic [ID_WIDTH-1:0] issue_tag;

  // State register.
  always_ff @(posedge i_clk_src or negedge i_rstn_src) begin
    if (!i_rstn_src) begin
      state <= ACTIVE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state plus accept and pop qualifiers.
  always_comb begin
    state_nxt        = state;
    o_ready          = 1'b0;
    o_rsp_fifo_rd_en = 1'b0;
    case (state)
      ACTIVE: begin
        if (i_src_sleep_req || i_sink_sleep_status) state_nxt = DRAIN;
        o_ready = !i_req_fifo_full && (o_outstanding != MAX_OUT);
      end
      DRAIN: begin
        if ((o_outstanding == '0) && i_req_fifo_empty && i_rsp_fifo_empty) state_nxt = SLEEP;
      end
      SLEEP: begin
        if (!i_src_sleep_req && !i_sink_sleep_status) state_nxt = WAKE;
      end
      WAKE: begin
        state_nxt = ACTIVE;
      end
      default: begin
        state_nxt = ACTIVE;
      end
    endcase
    if ((state == ACTIVE) || (state == DRAIN)) begin
`ifdef SRC_CTRL_RD_TIMEOUT_EN
      // Stale responses may remain after all reads have timed out; keep draining them.
      o_rsp_fifo_rd_en = !i_rsp_fifo_empty;
`else
      o_rsp_fifo_rd_en = !i_rsp_fifo_empty && (o_outstanding != '0);
`endif
    end
  end

  assign accept           = i_valid && o_ready;
  assign o_req_fifo_wr_en = accept;

  // Request packet; writes are posted and always carry tag 0.
  always_comb begin
    o_req_packet                                = '0;
    o_req_packet[REQ_TAG_LSB +: ID_WIDTH]       = i_rd0_wr1 ? '0 : issue_tag;
    o_req_packet[REQ_RW_BIT]                    = i_rd0_wr1;
    o_req_packet[REQ_ADDR_LSB +: ADDR_WIDTH]    = i_addr;
    o_req_packet[DATA_WIDTH-1:0]                = i_wr_data;
  end

  // Sleep status outputs and FIFO reset follow the SLEEP state one cycle late.
  always_ff @(posedge i_clk_src or negedge i_rstn_src) begin
    if (!i_rstn_src) begin
      o_fifo_rstn           <= 1'b1;
      o_src_sleep_ack       <= 1'b0;
      o_source_sleep_status <= 1'b0;
    end else begin
      o_fifo_rstn           <= (state != SLEEP);
      o_src_sleep_ack       <= (state == SLEEP) && i_src_sleep_req;
      o_source_sleep_status <= (state == SLEEP) && i_src_sleep_req;
    end
  end

  bridge_rsp_tracker #(
    .DATA_WIDTH     (DATA_WIDTH),
    .ID_WIDTH       (ID_WIDTH),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rsp_tracker (
    .i_clk_src   (i_clk_src),
    .i_rstn_src  (i_rstn_src),
    .rd_accept   (accept && !i_rd0_wr1),
    .pop         (o_rsp_fifo_rd_en),
    .clear_tags  (state == WAKE),
    .rsp_packet  (i_rsp_packet),
    .issue_tag   (issue_tag),
    .outstanding (o_outstanding),
    .rd_valid    (o_rd_valid),
    .rd_err      (o_rd_err),
    .rd_data     (o_rd_data)
  );

endmodule

// File: tb/tb_bridge_src_ctrl_mo.sv
// Directed bench for bridge_src_ctrl_mo (default build, MAX_OUTSTANDING=4, 32-bit paths).
// Table of single-cycle vectors for the request/response path, then hand sequences
// for drain/sleep/wake and reset while reads are in flight.
module tb_bridge_src_ctrl_mo;

  logic        clk;
  logic        rstn;
  logic        sleep_req;
  logic        sink_sleep;
  logic        valid;
  logic        rw;
  logic [31:0] addr;
  logic [31:0] wdat;
  logic        ready;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        rd_err;
  logic        req_full;
  logic        req_empty;
  logic        req_wr_en;
  logic [66:0] req_pkt;
  logic        rsp_empty;
  logic [34:0] rsp_pkt;
  logic        rsp_rd_en;
  logic [2:0]  outstanding;
  logic        sleep_ack;
  logic        src_sleep_status;
  logic        fifo_rstn;

  int total = 0;
  int bad   = 0;

  bridge_src_ctrl_mo #(
    .ADDR_WIDTH      (32),
    .DATA_WIDTH      (32),
    .MAX_OUTSTANDING (4),
    .TIMEOUT_CYCLES  (8)
  ) dut (
    .i_clk_src             (clk),
    .i_rstn_src            (rstn),
    .i_src_sleep_req       (sleep_req),
    .i_sink_sleep_status   (sink_sleep),
    .i_valid               (valid),
    .i_rd0_wr1             (rw),
    .i_addr                (addr),
    .i_wr_data             (wdat),
    .o_ready               (ready),
    .o_rd_data             (rd_data),
    .o_rd_valid            (rd_valid),
    .o_rd_err              (rd_err),
    .i_req_fifo_full       (req_full),
    .i_req_fifo_empty      (req_empty),
    .o_req_fifo_wr_en      (req_wr_en),
    .o_req_packet          (req_pkt),
    .i_rsp_fifo_empty      (rsp_empty),
    .i_rsp_packet          (rsp_pkt),
    .o_rsp_fifo_rd_en      (rsp_rd_en),
    .o_outstanding         (outstanding),
    .o_src_sleep_ack       (sleep_ack),
    .o_source_sleep_status (src_sleep_status),
    .o_fifo_rstn           (fifo_rstn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdat;
    logic        full;
    logic        rsp_empty;
    logic [34:0] rsp;
    logic        e_ready;
    logic        e_wr;
    logic [66:0] e_pkt;
    logic        e_rd_en;
    logic [2:0]  e_out;
    logic        e_vld;
    logic        e_err;
    logic [31:0] e_data;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string nm, input int idx, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%0h want=%0h", nm, idx, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0; sleep_req = 1'b0; sink_sleep = 1'b0;
    valid = 1'b0; rw = 1'b0; addr = '0; wdat = '0;
    req_full = 1'b0; req_empty = 1'b1; rsp_empty = 1'b1; rsp_pkt = '0;

    //        vld   rw    addr          wdat          full  rempt rsp                           rdy   wr    pkt                                       rd_en out   vld   err   data
    tbl[0]  = '{1'b1,1'b1,32'h1000,32'hDEADBEEF,1'b0,1'b1,35'h0,                       1'b1,1'b1,{2'd0,1'b1,32'h1000,32'hDEADBEEF},1'b0,3'd0,1'b0,1'b0,32'h0};
    tbl[1]  = '{1'b1,1'b1,32'h1004,32'h12345678,1'b1,1'b1,35'h0,                       1'b0,1'b0,{2'd0,1'b1,32'h1004,32'h12345678},1'b0,3'd0,1'b0,1'b0,32'h0};
    tbl[2]  = '{1'b1,1'b0,32'h2000,32'h0,       1'b0,1'b1,35'h0,                       1'b1,1'b1,{2'd0,1'b0,32'h2000,32'h0},       1'b0,3'd1,1'b0,1'b0,32'h0};
    tbl[3]  = '{1'b1,1'b0,32'h2004,32'h0,       1'b0,1'b1,35'h0,                       1'b1,1'b1,{2'd1,1'b0,32'h2004,32'h0},       1'b0,3'd2,1'b0,1'b0,32'h0};
    tbl[4]  = '{1'b1,1'b0,32'h2008,32'h0,       1'b0,1'b1,35'h0,                       1'b1,1'b1,{2'd2,1'b0,32'h2008,32'h0},       1'b0,3'd3,1'b0,1'b0,32'h0};
    tbl[5]  = '{1'b1,1'b0,32'h200C,32'h0,       1'b0,1'b1,35'h0,                       1'b1,1'b1,{2'd3,1'b0,32'h200C,32'h0},       1'b0,3'd4,1'b0,1'b0,32'h0};
    tbl[6]  = '{1'b1,1'b0,32'h2010,32'h0,       1'b0,1'b1,35'h0,                       1'b0,1'b0,{2'd0,1'b0,32'h2010,32'h0},       1'b0,3'd4,1'b0,1'b0,32'h0};
    tbl[7]  = '{1'b0,1'b1,32'h0,   32'h0,       1'b0,1'b0,{2'd0,1'b0,32'hA0},          1'b0,1'b0,{2'd0,1'b1,64'h0},                1'b1,3'd3,1'b1,1'b0,32'hA0};
    tbl[8]  = '{1'b0,1'b1,32'h0,   32'h0,       1'b0,1'b1,35'h0,                       1'b1,1'b0,{2'd0,1'b1,64'h0},                1'b0,3'd3,1'b0,1'b0,32'h0};
    tbl[9]  = '{1'b1,1'b0,32'h3000,32'h0,       1'b0,1'b0,{2'd1,1'b0,32'hA1},          1'b1,1'b1,{2'd0,1'b0,32'h3000,32'h0},       1'b1,3'd3,1'b1,1'b0,32'hA1};
    tbl[10] = '{1'b0,1'b1,32'h0,   32'h0,       1'b0,1'b0,{2'd3,1'b0,32'hB2},          1'b1,1'b0,{2'd0,1'b1,64'h0},                1'b1,3'd2,1'b1,1'b1,32'hB2};
    tbl[11] = '{1'b0,1'b1,32'h0,   32'h0,       1'b0,1'b0,{2'd3,1'b1,32'hC3},          1'b1,1'b0,{2'd0,1'b1,64'h0},                1'b1,3'd1,1'b1,1'b1,32'hC3};
    tbl[12] = '{1'b0,1'b1,32'h0,   32'h0,       1'b0,1'b0,{2'd0,1'b0,32'hD0},          1'b1,1'b0,{2'd0,1'b1,64'h0},                1'b1,3'd0,1'b1,1'b0,32'hD0};
    tbl[13] = '{1'b0,1'b1,32'h0,   32'h0,       1'b0,1'b0,{2'd1,1'b0,32'hE1},          1'b1,1'b0,{2'd0,1'b1,64'h0},                1'b0,3'd0,1'b0,1'b0,32'h0};
    tbl[14] = '{1'b0,1'b1,32'h0,   32'h0,       1'b0,1'b1,35'h0,                       1'b1,1'b0,{2'd0,1'b1,64'h0},                1'b0,3'd0,1'b0,1'b0,32'h0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out",       0, 96'(outstanding), 96'd0);
    chk("rst_rd_valid",  0, 96'(rd_valid), 96'd0);
    chk("rst_rd_err",    0, 96'(rd_err), 96'd0);
    chk("rst_rd_data",   0, 96'(rd_data), 96'd0);
    chk("rst_fifo_rstn", 0, 96'(fifo_rstn), 96'd1);
    chk("rst_ack",       0, 96'(sleep_ack), 96'd0);
    chk("rst_status",    0, 96'(src_sleep_status), 96'd0);
    rstn = 1'b1;
    step();
    chk("rst_ready",     0, 96'(ready), 96'd1);

    // Table-driven request/response path
    for (int i = 0; i < 15; i++) begin
      valid = tbl[i].vld; rw = tbl[i].rw; addr = tbl[i].addr; wdat = tbl[i].wdat;
      req_full = tbl[i].full; rsp_empty = tbl[i].rsp_empty; rsp_pkt = tbl[i].rsp;
      #1;
      chk("ready", i, 96'(ready), 96'(tbl[i].e_ready));
      chk("wr_en", i, 96'(req_wr_en), 96'(tbl[i].e_wr));
      chk("pkt",   i, 96'(req_pkt), 96'(tbl[i].e_pkt));
      chk("rd_en", i, 96'(rsp_rd_en), 96'(tbl[i].e_rd_en));
      step();
      chk("outstanding", i, 96'(outstanding), 96'(tbl[i].e_out));
      chk("rd_valid",    i, 96'(rd_valid), 96'(tbl[i].e_vld));
      if (tbl[i].e_vld) begin
        chk("rd_err",  i, 96'(rd_err), 96'(tbl[i].e_err));
        chk("rd_data", i, 96'(rd_data), 96'(tbl[i].e_data));
      end
    end

    // Drain with two reads in flight, then sleep (issue_tag=1, exp_tag=1 here)
    valid = 1'b1; rw = 1'b0; addr = 32'h4000; wdat = '0; req_full = 1'b0; rsp_empty = 1'b1;
    #1;
    chk("s_wr_en", 0, 96'(req_wr_en), 96'd1);
    chk("s_pkt",   0, 96'(req_pkt), 96'({2'd1, 1'b0, 32'h4000, 32'h0}));
    step();
    addr = 32'h4004; sleep_req = 1'b1;
    #1;
    chk("s_wr_en", 1, 96'(req_wr_en), 96'd1);
    chk("s_pkt",   1, 96'(req_pkt), 96'({2'd2, 1'b0, 32'h4004, 32'h0}));
    step();
    chk("s_out", 1, 96'(outstanding), 96'd2);
    addr = 32'h4008; rsp_empty = 1'b0; rsp_pkt = {2'd1, 1'b0, 32'h11};
    #1;
    chk("s_drain_ready", 2, 96'(ready), 96'd0);
    chk("s_drain_wr_en", 2, 96'(req_wr_en), 96'd0);
    chk("s_drain_rd_en", 2, 96'(rsp_rd_en), 96'd1);
    step();
    chk("s_rd_valid", 2, 96'(rd_valid), 96'd1);
    chk("s_rd_data",  2, 96'(rd_data), 96'h11);
    chk("s_out",      2, 96'(outstanding), 96'd1);
    valid = 1'b0; rsp_pkt = {2'd2, 1'b0, 32'h22};
    step();
    chk("s_rd_valid", 3, 96'(rd_valid), 96'd1);
    chk("s_rd_err",   3, 96'(rd_err), 96'd0);
    chk("s_rd_data",  3, 96'(rd_data), 96'h22);
    chk("s_out",      3, 96'(outstanding), 96'd0);
    rsp_empty = 1'b1;
    step();
    chk("s_entry_fifo_rstn", 4, 96'(fifo_rstn), 96'd1);
    chk("s_entry_ack",       4, 96'(sleep_ack), 96'd0);
    step();
    chk("s_fifo_rstn", 5, 96'(fifo_rstn), 96'd0);
    chk("s_ack",       5, 96'(sleep_ack), 96'd1);
    chk("s_status",    5, 96'(src_sleep_status), 96'd1);
    chk("s_ready",     5, 96'(ready), 96'd0);

    // Local request dropped but sink still asleep: remain in SLEEP
    sleep_req = 1'b0; sink_sleep = 1'b1;
    repeat (3) step();
    chk("hold_fifo_rstn", 0, 96'(fifo_rstn), 96'd0);
    chk("hold_ack",       0, 96'(sleep_ack), 96'd0);
    chk("hold_status",    0, 96'(src_sleep_status), 96'd0);

    // Sink wakes: one WAKE cycle, then ACTIVE with tags cleared
    sink_sleep = 1'b0;
    step();
    chk("wake_ready",     0, 96'(ready), 96'd0);
    chk("wake_fifo_rstn", 0, 96'(fifo_rstn), 96'd0);
    step();
    chk("act_fifo_rstn",  0, 96'(fifo_rstn), 96'd1);
    chk("act_ready",      0, 96'(ready), 96'd1);
    valid = 1'b1; rw = 1'b0; addr = 32'h5000;
    #1;
    chk("act_wr_en", 0, 96'(req_wr_en), 96'd1);
    chk("act_pkt",   0, 96'(req_pkt), 96'({2'd0, 1'b0, 32'h5000, 32'h0}));
    step();
    valid = 1'b0;
    chk("act_out", 0, 96'(outstanding), 96'd1);

    // Reset with a read in flight drops it immediately
    rstn = 1'b0;
    #1;
    chk("mid_rst_out",       0, 96'(outstanding), 96'd0);
    chk("mid_rst_fifo_rstn", 0, 96'(fifo_rstn), 96'd1);
    step();
    rstn = 1'b1;
    step();
    chk("post_rst_ready", 0, 96'(ready), 96'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
